bcd_time_counter: RTL and testbench

BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

---
 rtl/bcd_time_counter.sv | 136 +++++++++++++
 tb/tb_bcd_time_counter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - packed-BCD hh:mm:ss time-of-day counter with optional key-driven set mode
// Set mode (mode_key/inc_key, SET_HOUR/SET_MIN states) is compiled in only when TIME_SET_EN is defined.
module bcd_time_counter #(
    parameter logic [7:0] INIT_HOUR = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       mode_key,
    input  logic       inc_key,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic [1:0] mode,
    output logic       day_pulse
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_t;

    // Wraps to zero at or above max_v, or on a bad low digit, so a corrupted field self-heals.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v >= max_v || v[3:0] > 4'd9) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    logic [7:0] hour_q, hour_d;
    logic [7:0] minute_q, minute_d;
    logic [7:0] second_q, second_d;
    logic       day_q, day_d;
    logic       in_run;

`ifdef TIME_SET_EN
    mode_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign in_run = (state_q == RUN);
    assign mode   = state_q;
`else
    logic unused_keys;

    assign unused_keys = mode_key | inc_key;
    assign in_run      = 1'b1;
    assign mode        = RUN;
`endif

    always_comb begin
        hour_d   = hour_q;
        minute_d = minute_q;
        second_d = second_q;
        day_d    = 1'b0;
`ifdef TIME_SET_EN
        state_d  = state_q;
`endif

        // Seconds ripple into minutes and hours within one edge, so no partial carry is ever visible.
        if (in_run && tick_1hz) begin
            second_d = bcd_inc(second_q, 8'h59);
            if (second_q >= 8'h59) begin
                minute_d = bcd_inc(minute_q, 8'h59);
                if (minute_q >= 8'h59) begin
                    hour_d = bcd_inc(hour_q, 8'h23);
                    day_d  = (hour_q >= 8'h23);
                end
            end
        end

`ifdef TIME_SET_EN
        case (state_q)
            RUN: begin
                if (mode_key) begin
                    state_d = SET_HOUR;
                end
            end
            SET_HOUR: begin
                if (inc_key) begin
                    hour_d = bcd_inc(hour_q, 8'h23);
                end
                if (mode_key) begin
                    state_d = SET_MIN;
                end
            end
            SET_MIN: begin
                if (inc_key) begin
                    minute_d = bcd_inc(minute_q, 8'h59);
                end
                // Leaving set mode restarts the minute from a clean zero second.
                if (mode_key) begin
                    state_d  = RUN;
                    second_d = 8'h00;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hour_q   <= INIT_HOUR;
            minute_q <= 8'h00;
            second_q <= 8'h00;
            day_q    <= 1'b0;
        end else begin
            hour_q   <= hour_d;
            minute_q <= minute_d;
            second_q <= second_d;
            day_q    <= day_d;
        end
    end

    assign hour      = hour_q;
    assign minute    = minute_q;
    assign second    = second_q;
    assign day_pulse = day_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - self-checking bench for bcd_time_counter against a seconds-of-day model
module tb_bcd_time_counter;

    localparam logic [7:0] INIT_HOUR = 8'h23;
    localparam int         INIT_H    = 23;
`ifdef TIME_SET_EN
    localparam bit SET_EN = 1'b1;
`else
    localparam bit SET_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz;
    logic       mode_key;
    logic       inc_key;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
    logic [1:0] mode;
    logic       day_pulse;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    bcd_time_counter #(.INIT_HOUR(INIT_HOUR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1hz  (tick_1hz),
        .mode_key  (mode_key),
        .inc_key   (inc_key),
        .hour      (hour),
        .minute    (minute),
        .second    (second),
        .mode      (mode),
        .day_pulse (day_pulse)
    );

    always #5 clk = ~clk;

    // Model: time of day as plain seconds since midnight, mode as 0/1/2.
    typedef struct {
        int t;
        int md;
        bit day;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_reset();
        mstate_t r;
        r.t   = INIT_H * 3600;
        r.md  = 0;
        r.day = 1'b0;
        return r;
    endfunction

    function automatic mstate_t model_next(input mstate_t cur, input bit tk, input bit mk, input bit ik);
        mstate_t n;
        int h, mi, s;
        n     = cur;
        n.day = 1'b0;
        if (cur.md == 0 && tk) begin
            n.t = n.t + 1;
            if (n.t == 86400) begin
                n.t   = 0;
                n.day = 1'b1;
            end
        end
        if (SET_EN) begin
            h  = n.t / 3600;
            mi = (n.t / 60) % 60;
            s  = n.t % 60;
            if (cur.md == 1 && ik) h = (h + 1) % 24;
            if (cur.md == 2 && ik) mi = (mi + 1) % 60;
            if (mk) begin
                n.md = (cur.md + 1) % 3;
                if (cur.md == 2) s = 0;
            end
            n.t = h * 3600 + mi * 60 + s;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, tick_1hz, mode_key, inc_key);
    end

    function automatic logic [7:0] to_bcd(input int n);
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_hour", hour, to_bcd(m.t / 3600));
            chk("cyc_minute", minute, to_bcd((m.t / 60) % 60));
            chk("cyc_second", second, to_bcd(m.t % 60));
            chk("cyc_mode", {6'd0, mode}, 8'(m.md));
            chk("cyc_day", {7'd0, day_pulse}, {7'd0, m.day});
        end
    end

    task automatic chk_time(input string name, input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        chk({name, "_hour"}, hour, h);
        chk({name, "_minute"}, minute, mi);
        chk({name, "_second"}, second, s);
    endtask

    task automatic drive(input bit tk, input bit mk, input bit ik);
        tick_1hz = tk;
        mode_key = mk;
        inc_key  = ik;
        @(posedge clk);
        #2;
        tick_1hz = 1'b0;
        mode_key = 1'b0;
        inc_key  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n    = 1'b0;
        tick_1hz = 1'b0;
        mode_key = 1'b0;
        inc_key  = 1'b0;
        @(posedge clk);
        #2;
        cmp_en = 1'b1;
        chk_time("reset", 8'h23, 8'h00, 8'h00);
        chk("reset_mode", {6'd0, mode}, 8'h00);
        chk("reset_day", {7'd0, day_pulse}, 8'h00);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        ticks(59);
        chk("sec59", second, 8'h59);
        ticks(1);
        chk_time("carry", 8'h23, 8'h01, 8'h00);
        drive(1'b0, 1'b0, 1'b1);
        chk_time("run_inc_ignored", 8'h23, 8'h01, 8'h00);

`ifdef TIME_SET_EN
        drive(1'b0, 1'b1, 1'b0);
        chk("enter_set_hour", {6'd0, mode}, 8'h01);
        drive(1'b0, 1'b0, 1'b1);
        chk("hour_wrap", hour, 8'h00);
        chk("hour_wrap_day", {7'd0, day_pulse}, 8'h00);
        incs(13);
        chk("hour13", hour, 8'h13);
        chk("hour13_mode", {6'd0, mode}, 8'h01);
        ticks(3);
        chk_time("frozen", 8'h13, 8'h01, 8'h00);
        incs(10);
        drive(1'b0, 1'b1, 1'b0);
        chk("enter_set_min", {6'd0, mode}, 8'h02);
        incs(58);
        chk("min59", minute, 8'h59);
        drive(1'b0, 1'b0, 1'b1);
        chk_time("min_wrap", 8'h23, 8'h00, 8'h00);
        incs(59);
        ticks(2);
        chk_time("set_min_frozen", 8'h23, 8'h59, 8'h00);
        drive(1'b0, 1'b1, 1'b0);
        chk("back_to_run", {6'd0, mode}, 8'h00);
        ticks(59);
`else
        drive(1'b0, 1'b1, 1'b0);
        chk("mode_key_ignored", {6'd0, mode}, 8'h00);
        ticks(3539);
`endif
        chk_time("pre_wrap", 8'h23, 8'h59, 8'h59);
        ticks(1);
        chk_time("day_wrap", 8'h00, 8'h00, 8'h00);
        chk("day_pulse_hi", {7'd0, day_pulse}, 8'h01);
        drive(1'b0, 1'b0, 1'b0);
        chk("day_pulse_lo", {7'd0, day_pulse}, 8'h00);

        ticks(5);
        drive(1'b1, 1'b1, 1'b0);
        chk("tick_mode_sec", second, 8'h06);
        chk("tick_mode_mode", {6'd0, mode}, SET_EN ? 8'h01 : 8'h00);

`ifdef TIME_SET_EN
        ticks(2);
        chk_time("set_after_tick", 8'h00, 8'h00, 8'h06);
        drive(1'b0, 1'b1, 1'b1);
        chk("inc_mode_hour", hour, 8'h01);
        chk("inc_mode_mode", {6'd0, mode}, 8'h02);
        drive(1'b0, 1'b1, 1'b0);
        chk_time("exit_clear_sec", 8'h01, 8'h00, 8'h00);
        drive(1'b0, 1'b1, 1'b0);
        incs(11);
        drive(1'b0, 1'b1, 1'b0);
        incs(34);
        drive(1'b0, 1'b1, 1'b0);
        ticks(56);
        chk_time("preset", 8'h12, 8'h34, 8'h56);
        drive(1'b0, 1'b1, 1'b0);
`else
        ticks(100);
        chk_time("preset", 8'h00, 8'h01, 8'h46);
`endif

        rst_n = 1'b0;
        #1;
        chk_time("async_reset", 8'h23, 8'h00, 8'h00);
        chk("async_reset_mode", {6'd0, mode}, 8'h00);
        chk("async_reset_day", {7'd0, day_pulse}, 8'h00);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        ticks(1);
        chk_time("first_tick", 8'h23, 8'h00, 8'h01);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
